bitty_fetch: RTL and testbench
==============================

# bitty_fetch

Instruction fetch sequencer for the BittyPro core. It owns the program counter, reads 16-bit instructions from instruction memory over a request/valid handshake, and presents each instruction to the control unit. It holds that instruction stable until the control unit pulses `done`, then advances or branches the PC. It is the supplying end of the control unit's `inst`/`done` interface.

## Interface
- `ADDR_W`, default 8, instruction-memory address width (PC width).
- `INST_W`, default 16, instruction width; must match the control unit.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `run` input 1: enables fetching; sampled in IDLE and at each retire.
- `mem_req` output 1: read request; held high until accepted.
- `mem_addr` output ADDR_W: read address, equal to `pc` while `mem_req` is high.
- `mem_valid` input 1: read data valid; counts only while `mem_req` is high.
- `mem_rdata` input INST_W: read data.
- `inst` output INST_W: instruction register driven to the control unit.
- `inst_valid` output 1: `inst` is being executed.
- `done` input 1: control-unit completion pulse.
- `branch_en` input 1: take the branch; sampled only in the cycle `done` is high.
- `branch_target` input ADDR_W: next PC when the branch is taken.
- `pc` output ADDR_W: current program counter.
- `halted` output 1: a HALT instruction was fetched.
- `retired` output 16: count of instructions retired; wraps modulo 2^16.

## Operation
- States: IDLE, REQ, ISSUE, HALTED.
- **IDLE**
  - `mem_req`=0.
  - If `run`=1, go to REQ.
- **REQ**
  - `mem_req`=1 and `mem_addr`=`pc`.
  - When `mem_valid`=1, load `inst` <= `mem_rdata` and leave REQ.
  - If the fetched word equals HALT_INST (16'hFFFF), go to HALTED.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `inst_valid`=1; `inst` is frozen.
  - When `done`=1, the instruction retires:
    - `retired` increments.
    - `pc` <= `branch_target` if `branch_en`=1, else `pc`+1, wrapping from 2^ADDR_W−1 to 0.
    - `inst_valid` drops to 0.
  - After retiring, go to REQ if `run`=1, else IDLE.
- **HALTED**
  - `halted`=1 and `mem_req`=0.
  - `pc` stays at the HALT address; `inst` holds HALT_INST; `inst_valid`=0.
  - Only `reset` leaves this state.
- Ignored inputs:
  - `done` outside ISSUE is ignored.
  - `mem_valid` outside REQ is ignored.
  - `branch_en` without `done` is ignored.
- Deasserting `run` in REQ does not cancel an outstanding request. The fetch completes and the instruction executes; `run` is rechecked at retire.
- Reset values: state IDLE; `pc`=0, `inst`=0, `inst_valid`=0, `mem_req`=0, `halted`=0, `retired`=0. `mem_addr` follows `pc`.
- Reset in any state, including mid-request or mid-execution, aborts immediately. The next cycle shows the reset values. Any late `mem_valid` is ignored.

## Timing
- Run to request: `run` high in IDLE at edge N gives `mem_req`=1 from cycle N+1.
- `mem_valid` is accepted in the same cycle as `mem_req`, so a zero-wait memory is supported. `inst` and `inst_valid` update on the following edge.
- Retire to next fetch: the `done` edge updates `pc`, and `mem_req` rises in the next cycle. Minimum fetch overhead is 2 cycles per instruction with a zero-wait memory.
- `inst` changes only on the REQ→ISSUE transition or at reset. It is stable for the whole time `inst_valid`=1.
- `pc` changes only at retire or at reset.

## Structure
- Shared package `bitty_pkg` holds:
  - the fetch state enum;
  - `HALT_INST` = 16'hFFFF;
  - `INST_W` default 16.
- Single module; no sub-modules. The PC incrementer/branch mux is inline.

## Test plan
- **Reset then run:** reset, memory contents {0:16'h1234, 1:16'h5678}, `run`=1, zero-wait memory, `done` pulsed 3 cycles after each `inst_valid` rise → `inst`=16'h1234 then 16'h5678; `pc` 0→1→2; `retired`=2.
- **Wait states:** `mem_valid` delayed 4 cycles → `mem_req` and `mem_addr` held steady for 4 cycles; `inst_valid` stays 0 until capture.
- **Branch:** `branch_en`=1 and `branch_target`=8'h40 with `done` at `pc`=5 → next `mem_addr`=8'h40. `branch_en`=1 without `done` → no effect.
- **Wrap:** `ADDR_W`=8, `pc`=8'hFF retires without branch → `pc`=0.
- **Halt:** word 16'hFFFF at address 3 → `halted`=1, `mem_req`=0, `pc`=3 indefinitely. `done` and `run` have no effect. Reset clears `halted`.
- **Reset mid-op:** assert `reset` in REQ with `mem_valid` arriving in the same cycle, and separately in ISSUE → reset values one cycle later; `inst`=0; `retired` unchanged from 0.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared definitions for the BittyPro instruction fetch sequencer.
package bitty_pkg;

  localparam int INST_W = 16;
  localparam logic [15:0] HALT_INST = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/bitty_fetch_if.sv
// Fetch-side bus: instruction-memory read handshake plus the inst/done link to the control unit.
interface bitty_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = bitty_pkg::INST_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [INST_W-1:0] mem_rdata;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              done;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    output mem_req, mem_addr, inst, inst_valid,
    input  mem_valid, mem_rdata, done, branch_en, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, inst, inst_valid,
    output mem_valid, mem_rdata, done, branch_en, branch_target
  );
endinterface

// File: rtl/bitty_fetch.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time and holds it
// for the control unit until done, then advances or branches.
//
// state     | meaning
// ST_IDLE   | not fetching; waits for run
// ST_REQ    | mem_req high at pc; waits for mem_valid
// ST_ISSUE  | inst_valid high; waits for done to retire
// ST_HALTED | HALT word fetched; parked until reset
module bitty_fetch #(
  parameter int ADDR_W = 8,
  parameter int INST_W = bitty_pkg::INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  bitty_fetch_if.master     bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired
);
  import bitty_pkg::*;

  fetch_state_t      state, state_nxt;
  logic [INST_W-1:0] inst_q;
  logic              req_c;
  logic              issue_c;
  logic              halted_c;
  logic              capture;
  logic              retire;
  logic              is_halt;

  assign is_halt = (bus.mem_rdata == INST_W'(HALT_INST));
  assign capture = (state == ST_REQ) && bus.mem_valid;
  assign retire  = (state == ST_ISSUE) && bus.done;

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    issue_c   = 1'b0;
    halted_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (bus.mem_valid) state_nxt = is_halt ? ST_HALTED : ST_ISSUE;
      end
      ST_ISSUE: begin
        issue_c = 1'b1;
        if (bus.done) state_nxt = run ? ST_REQ : ST_IDLE;
      end
      ST_HALTED: begin
        halted_c = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      inst_q  <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (capture) inst_q <= bus.mem_rdata;
      // branch_en only matters on the retiring edge; pc+1 wraps naturally at ADDR_W bits
      if (retire) begin
        retired <= retired + 16'd1;
        pc      <= bus.branch_en ? bus.branch_target : pc + ADDR_W'(1);
      end
    end
  end

  assign bus.mem_req    = req_c;
  assign bus.mem_addr   = pc;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = issue_c;
  assign halted         = halted_c;

endmodule

// File: tb/tb_bitty_fetch.sv
// Self-checking bench for bitty_fetch: memory model, issue scoreboard, step table, corner sequences.
module tb_bitty_fetch;
  import bitty_pkg::*;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [AW-1:0] pc;
  logic          halted;
  logic [15:0]   retired;

  bitty_fetch_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  bitty_fetch #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus),
    .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory model: answers cur_lat cycles after mem_req is first seen
  logic [IW-1:0] mem [0:255];
  int  cur_lat = 0;
  bit  mem_en  = 1'b1;
  int  wcnt    = 0;

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && mem_en) begin
        if (wcnt >= cur_lat) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          wcnt = 0;
        end else begin
          bus.mem_valid = 1'b0;
          bus.mem_rdata = 16'hDEAD;
          wcnt++;
        end
      end else begin
        bus.mem_valid = 1'b0;
        wcnt = 0;
      end
    end
  end

  // scoreboard: every inst_valid rise must match the oldest expected {pc, inst}
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } fetch_exp_t;
  fetch_exp_t exp_q[$];
  logic iv_q = 1'b0;

  initial begin
    fetch_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.inst_valid && !iv_q) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got inst %0h at pc %0h, required no issue", bus.inst, pc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_inst", bus.inst, e.inst);
          chk("issue_pc", pc, e.pc);
        end
      end
      iv_q = bus.inst_valid;
    end
  end

  task automatic push_exp(input logic [AW-1:0] p, input logic [IW-1:0] w);
    fetch_exp_t e;
    e.pc   = p;
    e.inst = w;
    exp_q.push_back(e);
  endtask

  typedef struct {
    int            lat;
    bit            br;
    logic [AW-1:0] tgt;
    bit            run_at_done;
    logic [AW-1:0] exp_pc;
    logic [IW-1:0] exp_inst;
    logic [AW-1:0] exp_next;
  } step_t;

  localparam int NSTEP = 7;
  step_t tbl [NSTEP];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hold;
    bit stable;

    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h5678;
    mem[8'h02] = 16'h2222;
    mem[8'h03] = HALT_INST;
    mem[8'h05] = 16'h5555;
    mem[8'h40] = 16'h4040;
    mem[8'hFF] = 16'hF0F0;

    //            lat br  tgt    run pc     inst      next
    tbl[0] = '{0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h1234, 8'h01};
    tbl[1] = '{4, 1'b0, 8'h00, 1'b1, 8'h01, 16'h5678, 8'h02};
    tbl[2] = '{1, 1'b1, 8'h05, 1'b0, 8'h02, 16'h2222, 8'h05};
    tbl[3] = '{0, 1'b1, 8'h40, 1'b1, 8'h05, 16'h5555, 8'h40};
    tbl[4] = '{2, 1'b1, 8'hFF, 1'b1, 8'h40, 16'h4040, 8'hFF};
    tbl[5] = '{0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'hF0F0, 8'h00};
    tbl[6] = '{0, 1'b1, 8'h03, 1'b1, 8'h00, 16'h1234, 8'h03};

    reset = 1'b1; run = 1'b0;
    bus.done = 1'b0; bus.branch_en = 1'b0; bus.branch_target = '0;
    tick(); tick();
    chk("rst_pc", pc, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);

    reset = 1'b0;
    tick();
    chk("idle_no_req", bus.mem_req, 0);
    cur_lat = tbl[0].lat;
    run = 1'b1;
    tick();
    chk("run_to_req", bus.mem_req, 1);
    chk("run_addr", bus.mem_addr, 0);

    for (int i = 0; i < NSTEP; i++) begin
      push_exp(tbl[i].exp_pc, tbl[i].exp_inst);
      n = 0; hold = 0;
      while (!bus.inst_valid && n < 50) begin
        if (bus.mem_req && bus.mem_addr == tbl[i].exp_pc) hold++;
        tick();
        n++;
      end
      chk("fetch_arrived", bus.inst_valid, 1);
      chk("req_hold_cycles", hold, tbl[i].lat + 1);

      // branch_en without done must not move pc; inst stays frozen
      bus.branch_en = 1'b1; bus.branch_target = 8'h77;
      stable = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (bus.inst !== tbl[i].exp_inst || bus.inst_valid !== 1'b1 || pc !== tbl[i].exp_pc)
          stable = 1'b0;
      end
      chk("issue_stable", stable, 1);

      run = tbl[i].run_at_done;
      bus.branch_en = tbl[i].br;
      bus.branch_target = tbl[i].tgt;
      cur_lat = (i + 1 < NSTEP) ? tbl[i+1].lat : 0;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0; bus.branch_en = 1'b0;
      chk("retire_pc", pc, tbl[i].exp_next);
      chk("retire_count", retired, i + 1);
      chk("retire_iv_drop", bus.inst_valid, 0);
      chk("retire_next_req", bus.mem_req, tbl[i].run_at_done);
      if (!tbl[i].run_at_done) begin
        tick();
        chk("idle_hold", bus.mem_req, 0);
        run = 1'b1;
        tick();
        chk("restart_req", bus.mem_req, 1);
        chk("restart_addr", bus.mem_addr, tbl[i].exp_next);
      end
    end

    n = 0;
    while (!halted && n < 20) begin tick(); n++; end
    chk("halt_reached", halted, 1);
    chk("halt_mem_req", bus.mem_req, 0);
    chk("halt_pc", pc, 3);
    chk("halt_inst", bus.inst, HALT_INST);
    chk("halt_iv", bus.inst_valid, 0);
    chk("halt_retired", retired, NSTEP);
    bus.done = 1'b1; run = 1'b0; bus.branch_en = 1'b1; bus.branch_target = 8'h10;
    repeat (5) tick();
    bus.done = 1'b0; bus.branch_en = 1'b0; run = 1'b1;
    repeat (3) tick();
    chk("halt_sticky", halted, 1);
    chk("halt_pc_sticky", pc, 3);
    chk("halt_retired_sticky", retired, NSTEP);
    chk("halt_req_sticky", bus.mem_req, 0);
    chk("halt_no_pending", exp_q.size(), 0);

    run = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_reset_halted", halted, 0);
    chk("halt_reset_pc", pc, 0);
    chk("halt_reset_retired", retired, 0);
    chk("halt_reset_inst", bus.inst, 0);

    // reset while a request is outstanding, with mem_valid landing on the reset edge
    mem_en = 1'b0;
    run = 1'b1;
    tick(); tick();
    chk("mid_req_active", bus.mem_req, 1);
    cur_lat = 0; mem_en = 1'b1; reset = 1'b1;
    tick();
    chk("req_rst_mem_req", bus.mem_req, 0);
    chk("req_rst_inst", bus.inst, 0);
    chk("req_rst_iv", bus.inst_valid, 0);
    chk("req_rst_pc", pc, 0);
    chk("req_rst_retired", retired, 0);
    run = 1'b0; reset = 1'b0;
    tick(); tick();
    chk("late_valid_iv", bus.inst_valid, 0);
    chk("late_valid_inst", bus.inst, 0);

    // reset while executing, with done on the same edge
    push_exp(8'h00, 16'h1234);
    run = 1'b1;
    n = 0;
    while (!bus.inst_valid && n < 20) begin tick(); n++; end
    chk("mid_issue_active", bus.inst_valid, 1);
    reset = 1'b1; bus.done = 1'b1; bus.branch_en = 1'b1; bus.branch_target = 8'h22;
    tick();
    reset = 1'b0; bus.done = 1'b0; bus.branch_en = 1'b0; run = 1'b0;
    chk("iss_rst_inst", bus.inst, 0);
    chk("iss_rst_iv", bus.inst_valid, 0);
    chk("iss_rst_pc", pc, 0);
    chk("iss_rst_retired", retired, 0);
    chk("iss_rst_mem_req", bus.mem_req, 0);
    tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
